ecc_dec_ctrl: RTL and testbench

//  Sequences one decode transaction through the DEC_CHK syndrome/correction stage.
//  - Accepts a codeword and work mode on a valid/ready request port, then drives the checker's data_in/work_mod.
//  - Waits out the checker latency, captures the corrected word and error count, extracts the info field.
//  - Presents the result on a valid/ready response port with back-pressure.
//  - Keeps saturating single/double error statistics. Sits between the APB register block and the decode datapath.

---
 rtl/ecc_dec_ctrl_if.sv | 27 ++
 rtl/ecc_dec_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ecc_dec_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_dec_ctrl_if.sv
// Request/response handshake bundle for the ECC decode controller.
// master: the side that issues codewords and consumes results.
// slave:  the decode controller.
interface ecc_dec_ctrl_if #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int AMBA_WORD          = 32
);
    logic                          req_valid;
    logic                          req_ready;
    logic [MAX_CODEWORD_WIDTH-1:0] req_data;
    logic [AMBA_WORD-1:0]          req_work_mod;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [MAX_CODEWORD_WIDTH-1:0] rsp_data;
    logic [AMBA_WORD-1:0]          rsp_info;
    logic [1:0]                    rsp_num_of_errors;

    modport master (
        output req_valid, req_data, req_work_mod, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_info, rsp_num_of_errors
    );

    modport slave (
        input  req_valid, req_data, req_work_mod, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_info, rsp_num_of_errors
    );
endinterface

// File: rtl/ecc_dec_ctrl.sv
// Sequences one decode transaction through the syndrome/correction checker:
// accept a codeword, hold it on the checker inputs for the checker latency,
// capture the corrected word and error count, extract the info field and
// hand the result out with back-pressure. Keeps saturating error statistics.
module ecc_dec_ctrl #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int AMBA_WORD          = 32,
    parameter int CHK_LATENCY        = 1,
    parameter int STAT_WIDTH         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    ecc_dec_ctrl_if.slave                 bus,
    output logic [MAX_CODEWORD_WIDTH-1:0] chk_data_in,
    output logic [AMBA_WORD-1:0]          chk_work_mod,
    input  logic [MAX_CODEWORD_WIDTH-1:0] chk_data_out,
    input  logic [1:0]                    chk_num_of_errors,
    output logic                          busy,
    input  logic                          stat_clr,
    output logic [STAT_WIDTH-1:0]         stat_single,
    output logic [STAT_WIDTH-1:0]         stat_double
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(CHK_LATENCY);

    state_t                        state_reg;
    logic [2:0]                    wait_cnt_reg;
    logic                          illegal_reg;
    logic                          req_ready_reg;
    logic                          rsp_valid_reg;
    logic                          busy_reg;
    logic [MAX_CODEWORD_WIDTH-1:0] chk_data_in_reg;
    logic [AMBA_WORD-1:0]          chk_work_mod_reg;
    logic [MAX_CODEWORD_WIDTH-1:0] rsp_data_reg;
    logic [AMBA_WORD-1:0]          rsp_info_reg;
    logic [1:0]                    rsp_err_reg;

    logic [MAX_CODEWORD_WIDTH-1:0] info_src;
    logic [AMBA_WORD-1:0]          info_next;
    logic                          capt_legal;
    logic [1:0]                    stat_inc;
    logic [STAT_WIDTH-1:0]         stat_cnt [2];

    // Info field extraction; uncorrectable words report the bits as received.
    always_comb begin
        info_src  = (chk_num_of_errors == 2'd2) ? chk_data_in_reg : chk_data_out;
        info_next = '0;
        case (chk_work_mod_reg)
            AMBA_WORD'(0): info_next[3:0]  = info_src[7:4];
            AMBA_WORD'(1): info_next[10:0] = info_src[15:5];
            AMBA_WORD'(2): info_next[25:0] = info_src[31:6];
            default:       info_next       = '0;
        endcase
    end

    // Transaction sequencer with registered handshake and checker outputs.
    // Illegal modes skip WAIT but still pass through CAPT so the response is
    // registered one clock after acceptance and the checker is never sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= IDLE;
            wait_cnt_reg     <= '0;
            illegal_reg      <= 1'b0;
            req_ready_reg    <= 1'b0;
            rsp_valid_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            chk_data_in_reg  <= '0;
            chk_work_mod_reg <= '0;
            rsp_data_reg     <= '0;
            rsp_info_reg     <= '0;
            rsp_err_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    if (req_ready_reg && bus.req_valid) begin
                        req_ready_reg    <= 1'b0;
                        busy_reg         <= 1'b1;
                        chk_data_in_reg  <= bus.req_data;
                        chk_work_mod_reg <= bus.req_work_mod;
                        wait_cnt_reg     <= LAT;
                        if (bus.req_work_mod > AMBA_WORD'(2)) begin
                            illegal_reg <= 1'b1;
                            state_reg   <= CAPT;
                        end else begin
                            illegal_reg <= 1'b0;
                            state_reg   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    if (wait_cnt_reg <= 3'd1) begin
                        state_reg <= CAPT;
                    end
                end
                CAPT: begin
                    if (illegal_reg) begin
                        rsp_data_reg <= chk_data_in_reg;
                        rsp_info_reg <= '0;
                        rsp_err_reg  <= 2'd3;
                    end else begin
                        rsp_data_reg <= chk_data_out;
                        rsp_info_reg <= info_next;
                        rsp_err_reg  <= chk_num_of_errors;
                    end
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign capt_legal  = (state_reg == CAPT) && !illegal_reg;
    assign stat_inc[0] = capt_legal && (chk_num_of_errors == 2'd1);
    assign stat_inc[1] = capt_legal && (chk_num_of_errors == 2'd2);

    // One saturating counter per error class; clear wins over increment.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            logic [STAT_WIDTH-1:0] cnt_reg;

            // Count, hold at all-ones, clear on request.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (stat_clr) begin
                    cnt_reg <= '0;
                end else if (stat_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign stat_cnt[gi] = cnt_reg;
        end
    endgenerate

    assign bus.req_ready         = req_ready_reg;
    assign bus.rsp_valid         = rsp_valid_reg;
    assign bus.rsp_data          = rsp_data_reg;
    assign bus.rsp_info          = rsp_info_reg;
    assign bus.rsp_num_of_errors = rsp_err_reg;
    assign chk_data_in           = chk_data_in_reg;
    assign chk_work_mod          = chk_work_mod_reg;
    assign busy                  = busy_reg;
    assign stat_single           = stat_cnt[0];
    assign stat_double           = stat_cnt[1];

endmodule

// File: tb/tb_ecc_dec_ctrl.sv
// Bench for ecc_dec_ctrl: directed scenarios plus randomized transactions,
// checked against a behavioural model of the checker, info extraction and
// saturating statistics.
module tb_ecc_dec_ctrl;

    localparam int CW  = 32;
    localparam int AW  = 32;
    localparam int LAT = 1;
    localparam int SW  = 6;
    localparam int STAT_MAX = (1 << SW) - 1;

    logic          clk;
    logic          rst;
    logic [CW-1:0] chk_data_in;
    logic [AW-1:0] chk_work_mod;
    logic [CW-1:0] chk_data_out;
    logic [1:0]    chk_num_of_errors;
    logic          busy;
    logic          stat_clr;
    logic [SW-1:0] stat_single;
    logic [SW-1:0] stat_double;

    int n_checks;
    int n_errors;
    int n_txn;
    int exp_single;
    int exp_double;

    // Plan for the checker model: corrected = input ^ plan_mask.
    logic [CW-1:0] plan_mask;
    logic [1:0]    plan_err;
    logic [CW-1:0] pipe_data [LAT];
    logic [1:0]    pipe_err  [LAT];

    ecc_dec_ctrl_if #(.MAX_CODEWORD_WIDTH(CW), .AMBA_WORD(AW)) bus ();

    ecc_dec_ctrl #(
        .MAX_CODEWORD_WIDTH(CW),
        .AMBA_WORD(AW),
        .CHK_LATENCY(LAT),
        .STAT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .chk_data_in(chk_data_in),
        .chk_work_mod(chk_work_mod),
        .chk_data_out(chk_data_out),
        .chk_num_of_errors(chk_num_of_errors),
        .busy(busy),
        .stat_clr(stat_clr),
        .stat_single(stat_single),
        .stat_double(stat_double)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker model: a LAT-deep delay line behind the planned correction.
    always @(posedge clk) begin
        pipe_data[0] <= chk_data_in ^ plan_mask;
        pipe_err[0]  <= plan_err;
        for (int i = 1; i < LAT; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_err[i]  <= pipe_err[i-1];
        end
    end
    assign chk_data_out      = pipe_data[LAT-1];
    assign chk_num_of_errors = pipe_err[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_info(input logic [31:0] mode, input logic [31:0] word);
        case (mode)
            0:       return (word >> 4) & 32'hF;
            1:       return (word >> 5) & 32'h7FF;
            2:       return word >> 6;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= STAT_MAX) ? STAT_MAX : v + 1;
    endfunction

    task automatic wait_ready();
        int c;
        c = 0;
        while (!bus.req_ready && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check("req_ready_timeout", {63'd0, bus.req_ready}, 64'd1);
    endtask

    // One full transaction: request, latency, result, optional stall, handshake.
    task automatic do_txn(input logic [31:0] data, input logic [31:0] mode,
                          input logic [31:0] mask, input logic [1:0] err,
                          input int stall, input bit clr_at_capt);
        int cycles;
        int exp_lat;
        bit illegal;
        logic [31:0] exp_data;
        logic [31:0] exp_info;
        logic [1:0]  exp_err;
        illegal   = (mode > 2);
        exp_lat   = illegal ? 1 : LAT + 1;
        plan_mask = mask;
        plan_err  = err;
        if (illegal) begin
            exp_data = data;
            exp_info = 32'h0;
            exp_err  = 2'd3;
        end else begin
            exp_data = data ^ mask;
            exp_info = ref_info(mode, (err == 2'd2) ? data : (data ^ mask));
            exp_err  = err;
        end
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_data     = data;
        bus.req_work_mod = mode;
        @(posedge clk); #1;
        bus.req_valid    = 1'b0;
        bus.req_data     = $urandom();
        bus.req_work_mod = $urandom_range(0, 3);
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        check("req_ready_after_accept", {63'd0, bus.req_ready}, 64'd0);
        cycles = 0;
        while (!bus.rsp_valid && cycles < 20) begin
            stat_clr = clr_at_capt && (cycles == exp_lat - 1);
            @(posedge clk); #1;
            cycles++;
        end
        stat_clr = 1'b0;
        check("rsp_latency", 64'(cycles), 64'(exp_lat));
        check("rsp_data", 64'(bus.rsp_data), 64'(exp_data));
        check("rsp_info", 64'(bus.rsp_info), 64'(exp_info));
        check("rsp_err", 64'(bus.rsp_num_of_errors), 64'(exp_err));
        if (clr_at_capt) begin
            exp_single = 0;
            exp_double = 0;
        end else if (!illegal) begin
            if (err == 2'd1) exp_single = sat_inc(exp_single);
            if (err == 2'd2) exp_double = sat_inc(exp_double);
        end
        check("stat_single", 64'(stat_single), 64'(exp_single));
        check("stat_double", 64'(stat_double), 64'(exp_double));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check("stall_valid", {63'd0, bus.rsp_valid}, 64'd1);
            check("stall_data", 64'(bus.rsp_data), 64'(exp_data));
            check("stall_info", 64'(bus.rsp_info), 64'(exp_info));
            check("stall_req_ready", {63'd0, bus.req_ready}, 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("rsp_valid_after_hs", {63'd0, bus.rsp_valid}, 64'd0);
        n_txn++;
        $display("txn %0d mode=%0d data=%08h rsp_data=%08h info=%08h err=%0d single=%0d double=%0d",
                 n_txn, mode, data, bus.rsp_data, bus.rsp_info, bus.rsp_num_of_errors,
                 stat_single, stat_double);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_txn    = 0;
        exp_single = 0;
        exp_double = 0;
        rst = 1'b0;
        stat_clr = 1'b0;
        plan_mask = '0;
        plan_err  = '0;
        bus.req_valid = 1'b0;
        bus.req_data = '0;
        bus.req_work_mod = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_chk_data_in", 64'(chk_data_in), 64'd0);
        check("rst_stat_single", 64'(stat_single), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("req_ready_after_rst", {63'd0, bus.req_ready}, 64'd1);

        // 1: mode 0, single corrected error
        do_txn(32'h000000A5, 32'd0, 32'h00000001, 2'd1, 0, 1'b0);
        // 2: mode 2, clean word
        do_txn(32'hFFFFFFC0, 32'd2, 32'h00000000, 2'd0, 0, 1'b0);
        // 3: mode 1, uncorrectable, consumer stalls 5 clocks
        do_txn(32'h0000FFE1, 32'd1, 32'h00000001, 2'd2, 5, 1'b0);
        // 4: illegal mode, checker output must be ignored
        do_txn(32'h12345678, 32'd3, 32'hFFFF0000, 2'd1, 0, 1'b0);

        // 5: reset while waiting on the checker
        plan_mask = 32'h1;
        plan_err  = 2'd1;
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_data     = 32'h000000F0;
        bus.req_work_mod = 32'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("abort_stat_single", 64'(stat_single), 64'd0);
        check("abort_stat_double", 64'(stat_double), 64'd0);
        rst = 1'b1;
        exp_single = 0;
        exp_double = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        end
        check("abort_req_ready", {63'd0, bus.req_ready}, 64'd1);

        // 6: saturate the single-error counter, then clear on a CAPT cycle
        for (int k = 0; k <= STAT_MAX; k++) begin
            do_txn($urandom(), 32'd0, 32'h00000010, 2'd1, 0, 1'b0);
        end
        check("stat_single_sat", 64'(stat_single), 64'(STAT_MAX));
        do_txn(32'h00000033, 32'd1, 32'h00000100, 2'd1, 0, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  e;
            logic [31:0] m;
            e = 2'($urandom_range(0, 2));
            m = (e == 2'd0) ? 32'h0 : (32'h1 << $urandom_range(0, 31));
            do_txn($urandom(), 32'($urandom_range(0, 3)), m, e, $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
